// File: rtl/io_bus_target_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_target_if
//  Description : CPU memory-stage bus signals seen by an IO-window responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_target_if;
    logic [31:0] b_addr_i;
    logic [31:0] b_data_i;
    logic        b_read_i;
    logic        b_write_i;
    logic [31:0] b_data_o;
    logic        b_ack_o;

    modport master (
        output b_addr_i, b_data_i, b_read_i, b_write_i,
        input  b_data_o, b_ack_o
    );

    modport slave (
        input  b_addr_i, b_data_i, b_read_i, b_write_i,
        output b_data_o, b_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/io_bus_target.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_target
//  Description : IO-window bus responder with wait states, TX/RX word FIFOs
//                and a scratch register.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_target #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    io_bus_target_if.slave   bus,
    output logic [31:0]      tx_data_o,
    output logic             tx_valid_o,
    input  wire logic        tx_ready_i,
    input  wire logic [31:0] rx_data_i,
    input  wire logic        rx_valid_i,
    output logic             rx_ready_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_depth     = CW'(FIFO_DEPTH);
    localparam logic [3:0]    c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [5:0] c_off_txdata  = 6'h00;
    localparam logic [5:0] c_off_rxdata  = 6'h01;
    localparam logic [5:0] c_off_status  = 6'h02;
    localparam logic [5:0] c_off_scratch = 6'h03;
    localparam logic [5:0] c_off_ctrl    = 6'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [31:0]   r_scratch;

    logic [31:0]   r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wr;
    logic [AW-1:0] r_tx_rd;
    logic [CW-1:0] r_tx_cnt;

    logic [31:0]   r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wr;
    logic [AW-1:0] r_rx_rd;
    logic [CW-1:0] r_rx_cnt;

    logic          w_req;
    logic          w_is_wr;
    logic [5:0]    w_off;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_tx_stall;
    logic          w_go_ack;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_tx_flush;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_flush;
    logic          w_scratch_we;
    logic [31:0]   w_rdata;
    logic [31:0]   w_status;
    logic          w_unused;

    // ------------------------------------------------------------------
    // Request decode (address and data are held stable until ack)
    // ------------------------------------------------------------------
    assign w_req   = (bus.b_read_i | bus.b_write_i) && (bus.b_addr_i[31:8] == BASE_ADDR);
    assign w_is_wr = bus.b_write_i;
    assign w_off   = bus.b_addr_i[7:2];
    assign w_unused = ^bus.b_addr_i[1:0];

    assign w_tx_full  = (r_tx_cnt == c_depth);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_depth);
    assign w_rx_empty = (r_rx_cnt == '0);

    // Uses the registered full flag so a pop on this edge cannot release the stall early.
    assign w_tx_stall = w_is_wr && (w_off == c_off_txdata) && w_tx_full;

    always_comb begin
        w_go_ack = 1'b0;
        case (r_state)
            ST_IDLE: w_go_ack = w_req && (WAIT_CYCLES == 0) && !w_tx_stall;
            ST_WAIT: w_go_ack = (r_wait_cnt == 4'd0) && !w_tx_stall;
            default: w_go_ack = 1'b0;
        endcase
    end

    // Side effects commit only on the edge that enters ACK.
    assign w_tx_push    = w_go_ack &&  w_is_wr && (w_off == c_off_txdata) && !w_tx_full;
    assign w_rx_pop     = w_go_ack && !w_is_wr && (w_off == c_off_rxdata) && !w_rx_empty;
    assign w_scratch_we = w_go_ack &&  w_is_wr && (w_off == c_off_scratch);
    assign w_tx_flush   = w_go_ack &&  w_is_wr && (w_off == c_off_ctrl) && bus.b_data_i[0];
    assign w_rx_flush   = w_go_ack &&  w_is_wr && (w_off == c_off_ctrl) && bus.b_data_i[1];

    assign w_tx_pop  = tx_valid_o && tx_ready_i;
    assign w_rx_push = rx_valid_i && rx_ready_o;

    assign w_status = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt),
                       4'h0, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

    always_comb begin
        w_rdata = 32'h0;
        if (!w_is_wr) begin
            case (w_off)
                c_off_rxdata:  w_rdata = w_rx_empty ? 32'h0 : r_rx_mem[r_rx_rd];
                c_off_status:  w_rdata = w_status;
                c_off_scratch: w_rdata = r_scratch;
                default:       w_rdata = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered ack and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_ack      <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_ack   <= w_go_ack;
            r_rdata <= w_go_ack ? w_rdata : 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_ack) begin
                        r_state <= ST_ACK;
                    end else if (w_req) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= c_wait_load;
                    end
                end
                ST_WAIT: begin
                    if (w_go_ack) begin
                        r_state <= ST_ACK;
                    end else if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.b_ack_o  = r_ack;
    assign bus.b_data_o = r_rdata;

    // ------------------------------------------------------------------
    // Scratch register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scratch <= 32'h0;
        end else if (w_scratch_we) begin
            r_scratch <= bus.b_data_i;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (CPU -> peripheral)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= bus.b_data_i;
        end
    end

    // Flush has priority over any push or pop on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rd <= r_tx_rd + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    assign tx_valid_o = !w_tx_empty;
    assign tx_data_o  = w_tx_empty ? 32'h0 : r_tx_mem[r_tx_rd];

    // ------------------------------------------------------------------
    // RX FIFO (peripheral -> CPU)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else if (w_rx_flush) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    assign rx_ready_o = !w_rx_full;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_target
//  Description : Directed, table-driven self-checking bench for io_bus_target.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_target;

    logic        clk;
    logic        rst;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;

    int checks   = 0;
    int failures = 0;

    io_bus_target_if bus ();

    io_bus_target #(
        .BASE_ADDR   (24'h000000),
        .FIFO_DEPTH  (8),
        .WAIT_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction; lat is the cycle of ack counted from the request cycle, -1 on timeout.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int budget, output logic [31:0] rdata, output int lat);
        lat   = -1;
        rdata = 32'h0;
        @(posedge clk);
        #1;
        bus.b_addr_i  = addr;
        bus.b_data_i  = wdata;
        bus.b_write_i = wr;
        bus.b_read_i  = !wr;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.b_ack_o) begin
                lat   = c;
                rdata = bus.b_data_o;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.b_write_i = 1'b0;
        bus.b_read_i  = 1'b0;
        if (lat >= 0) begin
            @(negedge clk);
            check("ack_one_cycle", {31'h0, bus.b_ack_o}, 32'h0);
        end
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int          l;
        xfer(1'b0, addr, 32'h0, 40, d, l);
        check({name, "_lat"}, 32'(l), 32'd2);
        check(name, d, exp);
    endtask

    task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        int          l;
        xfer(1'b1, addr, data, 40, d, l);
        check({name, "_lat"}, 32'(l), 32'd2);
    endtask

    task automatic tx_pop_pulse();
        @(posedge clk);
        #1 tx_ready_i = 1'b1;
        @(posedge clk);
        #1 tx_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          l;
        int          acks;

        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0005, 1'b1,  2};
        vecs[1]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF,  32'h0,         1'b0,  2};
        vecs[2]  = '{1'b0, 32'h0000_000C, 32'h0,          32'hDEAD_BEEF, 1'b1,  2};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0,         1'b1,  2};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,          32'h0,         1'b1,  2};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'h0000_1234,  32'h0,         1'b0,  2};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,          32'h0,         1'b1,  2};
        vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,          32'h0,         1'b1,  2};
        vecs[8]  = '{1'b1, 32'h0000_000F, 32'h0000_5A5A,  32'h0,         1'b0,  2};
        vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,          32'h0000_5A5A, 1'b1,  2};
        vecs[10] = '{1'b0, 32'h0000_0108, 32'h0,          32'h0,         1'b0, -1};
        vecs[11] = '{1'b1, 32'h0000_0000, 32'h0000_0099,  32'h0,         1'b0,  2};
        vecs[12] = '{1'b1, 32'h0000_0000, 32'h0000_0098,  32'h0,         1'b0,  2};
        vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0204, 1'b1,  2};
        vecs[14] = '{1'b1, 32'h0000_0010, 32'h0000_0001,  32'h0,         1'b0,  2};
        vecs[15] = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0005, 1'b1,  2};
        vecs[16] = '{1'b1, 32'h0000_010C, 32'hFFFF_FFFF,  32'h0,         1'b0, -1};
        vecs[17] = '{1'b0, 32'h0000_000C, 32'h0,          32'h0000_5A5A, 1'b1,  2};
        vecs[18] = '{1'b0, 32'h0000_0014, 32'h0,          32'h0,         1'b1,  2};

        rst           = 1'b1;
        bus.b_addr_i  = 32'h0;
        bus.b_data_i  = 32'h0;
        bus.b_read_i  = 1'b0;
        bus.b_write_i = 1'b0;
        tx_ready_i    = 1'b0;
        rx_data_i     = 32'h0;
        rx_valid_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ack",      {31'h0, bus.b_ack_o}, 32'h0);
        check("rst_data",     bus.b_data_o,         32'h0);
        check("rst_tx_valid", {31'h0, tx_valid_o},  32'h0);
        check("rst_tx_data",  tx_data_o,            32'h0);
        check("rst_rx_ready", {31'h0, rx_ready_o},  32'h1);

        for (int i = 0; i < 19; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 12, d, l);
            check($sformatf("vec%0d_lat", i), 32'(l), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_rdata) begin
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
        end

        // TX fills to 8 with no consumer; the 9th write stalls until one pop frees a slot.
        for (int k = 1; k <= 8; k++) begin
            wr_chk($sformatf("tx_fill%0d", k), 32'h0, 32'(k));
        end
        rd_chk("status_tx_full", 32'h8, 32'h0000_0806);
        fork
            begin
                xfer(1'b1, 32'h0, 32'h9, 40, d, l);
                check("tx_stall_lat", 32'(l), 32'd8);
            end
            begin
                @(posedge clk);
                repeat (6) @(posedge clk);
                check("tx_stall_noack", {31'h0, bus.b_ack_o}, 32'h0);
                check("tx_head_pop",    tx_data_o,            32'h1);
                #1 tx_ready_i = 1'b1;
                @(posedge clk);
                #1 tx_ready_i = 1'b0;
            end
        join
        @(posedge clk);
        #1 tx_ready_i = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("tx_drain%0d", k), tx_data_o, 32'(k));
        end
        @(posedge clk);
        #1 tx_ready_i = 1'b0;
        @(negedge clk);
        check("tx_drained", {31'h0, tx_valid_o}, 32'h0);

        // RX: three words in, read back in order, then empty read returns 0.
        @(posedge clk);
        #1 rx_valid_i = 1'b1; rx_data_i = 32'hA;
        @(posedge clk);
        #1 rx_data_i = 32'hB;
        @(posedge clk);
        #1 rx_data_i = 32'hC;
        @(posedge clk);
        #1 rx_valid_i = 1'b0;
        rd_chk("status_rx3", 32'h8, 32'h0003_0001);
        rd_chk("rx_pop_a",   32'h4, 32'hA);
        rd_chk("rx_pop_b",   32'h4, 32'hB);
        rd_chk("rx_pop_c",   32'h4, 32'hC);
        rd_chk("rx_pop_mt",  32'h4, 32'h0);
        rd_chk("status_rx0", 32'h8, 32'h0000_0005);

        @(posedge clk);
        #1 rx_valid_i = 1'b1; rx_data_i = 32'hD;
        @(posedge clk);
        #1 rx_valid_i = 1'b0;
        rd_chk("status_rx1", 32'h8, 32'h0001_0001);
        wr_chk("rx_flush",   32'h10, 32'h2);
        rd_chk("status_rxf", 32'h8, 32'h0000_0005);

        // Request held high across two TXDATA writes: each ack starts a fresh transaction.
        acks = 0;
        @(posedge clk);
        #1;
        bus.b_addr_i  = 32'h0;
        bus.b_data_i  = 32'h11;
        bus.b_write_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.b_ack_o) begin
                acks++;
                @(posedge clk);
                #1;
                if (acks == 1) bus.b_data_i = 32'h22;
                else           bus.b_write_i = 1'b0;
            end
        end
        bus.b_write_i = 1'b0;
        check("held_acks", 32'(acks), 32'd2);
        @(negedge clk);
        check("held_head0", tx_data_o, 32'h11);
        tx_pop_pulse();
        @(negedge clk);
        check("held_head1", tx_data_o, 32'h22);
        tx_pop_pulse();
        @(negedge clk);
        check("held_empty", {31'h0, tx_valid_o}, 32'h0);

        // Reset while a TXDATA write sits in WAIT: dropped with no side effect.
        @(posedge clk);
        #1;
        bus.b_addr_i  = 32'h0;
        bus.b_data_i  = 32'h77;
        bus.b_write_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstw_ack",  {31'h0, bus.b_ack_o}, 32'h0);
        check("rstw_data", bus.b_data_o,         32'h0);
        bus.b_write_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rstw_rx_ready", {31'h0, rx_ready_o}, 32'h1);
        rd_chk("rstw_status",  32'h8, 32'h0000_0005);
        rd_chk("rstw_scratch", 32'hC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
